filter_acc_sat: RTL and testbench
=================================

FILTER_ACC_SAT -- requirements
Module: filter_acc_sat

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 33: signed product width from the upstream multiplier stage.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: signed accumulator width; supports up to 128 taps without overflow.
REQ-003 SHALL have parameter FRAC_BITS, default 17: coefficient fraction bits removed at output.
REQ-004 SHALL have parameter OUT_WIDTH, default 16: output sample width.
REQ-005 SHALL have port ap_clk, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port ap_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port prod_data, input, PROD_WIDTH: signed tap product.
REQ-008 SHALL have port prod_valid, input, 1: prod_data valid.
REQ-009 SHALL have port prod_last, input, 1: final tap of the current sample.
REQ-010 SHALL have port prod_ready, output, 1: block accepts a product this cycle.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: rounded, saturated signed sample.
REQ-012 SHALL have port out_valid, output, 1: out_data valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts out_data.

Function
REQ-014 SHALL accept a product on a cycle where prod_valid and prod_ready are both high (a beat).
REQ-015 SHALL implement states IDLE, ACCUM and HOLD.
REQ-016 IDLE: first beat loads acc = sign-extended prod_data; go to ACCUM, or HOLD if prod_last.
REQ-017 ACCUM: each beat sets acc = acc + prod_data; prod_last beat goes to HOLD.
REQ-018 On entry to HOLD, SHALL register out_data = sat(round(final acc)) with out_valid=1; latency is 1 cycle after the last beat.
REQ-019 round: add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
REQ-020 sat: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], i.e. [-32768, 32767].
REQ-021 prod_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-022 HOLD: out_data and out_valid stable until out_ready; the out_valid&out_ready cycle returns to IDLE, with prod_ready high the next cycle.
REQ-023 A single-beat sample (prod_valid, prod_last on the IDLE beat) SHALL be legal.
REQ-024 Accumulator overflow beyond ACC_WIDTH SHALL wrap (two's complement); it is not detected.

Reset
REQ-025 ap_rst_n low SHALL immediately force state IDLE, acc=0, out_data=0, out_valid=0; prod_ready=1 once released.
REQ-026 Reset mid-sample or in HOLD SHALL discard the partial or pending sample with no output.

Configuration
REQ-027 With FILTER_ACC_SAT_STATUS_EN defined: output port sat_count, 16 bits, increments on each output sample that was clamped, saturates at 0xFFFF, resets to 0.
REQ-028 Without FILTER_ACC_SAT_STATUS_EN: no sat_count port, and there is no saturation-count logic.

Structure
REQ-029 Shared package filter_pkg SHALL hold the state enum and the default width constants (33/40/17/16).
REQ-030 Round/saturate SHALL be one combinational sub-module filter_round_sat (ACC_WIDTH in, OUT_WIDTH out, clamp flag out).

Verification
REQ-031 Single tap: prod 65,536,000 (1000 x 0.5 in Q1.17) with last -> out_data=500, one cycle later.
REQ-032 Rounding: acc 65,536 -> 1 (half up); acc -65,537 -> -1; acc -65,536 -> 0.
REQ-033 Saturation: 3 beats of 2^32-1 -> out_data=32767 (sat_count=1 when enabled); 3 beats of -2^32 -> -32768.
REQ-034 Backpressure: out_ready low 5 cycles -> out_data stable, prod_ready=0 throughout, no beat lost; release -> next sample accumulates cleanly.
REQ-035 Reset after 3 of 8 taps -> no out_valid; a subsequent 8-tap sample of products 131,072 each -> out_data=8.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and default widths for the filter accumulate/round/saturate slice.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned DEF_PROD_WIDTH = 33;
  localparam int unsigned DEF_ACC_WIDTH  = 40;
  localparam int unsigned DEF_FRAC_BITS  = 17;
  localparam int unsigned DEF_OUT_WIDTH  = 16;

endpackage

// File: rtl/filter_round_sat.sv
// Combinational round-half-up, drop FRAC_BITS, clamp to a signed OUT_WIDTH range.
module filter_round_sat
  import filter_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic        [OUT_WIDTH-1:0] sat_data,
  output logic                        clamp
);

  // One guard bit so adding the rounding half can never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF =
    {{(ACC_WIDTH+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] MAX_V =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_V =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] rounded;
  logic signed [ACC_WIDTH:0] shifted;

  always_comb begin
    rounded = {acc_in[ACC_WIDTH-1], acc_in} + HALF;
    shifted = rounded >>> FRAC_BITS;
    if (shifted > MAX_V) begin
      sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      clamp    = 1'b1;
    end else if (shifted < MIN_V) begin
      sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      clamp    = 1'b1;
    end else begin
      sat_data = shifted[OUT_WIDTH-1:0];
      clamp    = 1'b0;
    end
  end

endmodule

// File: rtl/filter_acc_sat.sv
// FIR tail: accumulate tap products, emit one rounded/saturated sample per prod_last.
// Optional FILTER_ACC_SAT_STATUS_EN adds a saturating count of clamped samples (sat_count).
module filter_acc_sat
  import filter_pkg::*;
#(
  parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FILTER_ACC_SAT_STATUS_EN
 ,output logic [15:0]           sat_count
`endif
);

  state_t                      state, state_next;
  logic signed [ACC_WIDTH-1:0] acc, acc_next, prod_ext;
  logic [OUT_WIDTH-1:0]        sat_data;
  logic                        beat;

  assign prod_ext   = ACC_WIDTH'($signed(prod_data));
  assign prod_ready = (state != HOLD);
  assign beat       = prod_valid && prod_ready;

  always_comb begin
    state_next = state;
    acc_next   = acc;
    case (state)
      IDLE: if (beat) begin
        acc_next   = prod_ext;
        state_next = prod_last ? HOLD : ACCUM;
      end
      ACCUM: if (beat) begin
        acc_next   = acc + prod_ext;
        state_next = prod_last ? HOLD : ACCUM;
      end
      HOLD: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  // Rounding works on acc_next so the sample is registered on the last beat itself.
`ifdef FILTER_ACC_SAT_STATUS_EN
  logic clamp;

  filter_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .acc_in   (acc_next),
    .sat_data (sat_data),
    .clamp    (clamp)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_count <= '0;
    end else if (beat && prod_last && clamp && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  filter_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .acc_in   (acc_next),
    .sat_data (sat_data),
    .clamp    ()
  );
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (beat && prod_last) begin
      out_data  <= sat_data;
      out_valid <= 1'b1;
    end else if ((state == HOLD) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_filter_acc_sat.sv
// Self-checking bench for filter_acc_sat: directed corner cases plus random samples vs. an arithmetic model.
module tb_filter_acc_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [32:0] prod_data = '0;
  logic        prod_valid = 1'b0;
  logic        prod_last = 1'b0;
  logic        prod_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef FILTER_ACC_SAT_STATUS_EN
  logic [15:0] sat_count;
`endif

  filter_acc_sat #(
    .PROD_WIDTH (33),
    .ACC_WIDTH  (40),
    .FRAC_BITS  (17),
    .OUT_WIDTH  (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_data  (prod_data),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FILTER_ACC_SAT_STATUS_EN
   ,.sat_count  (sat_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int     n_checks = 0;
  int     n_errors = 0;
  longint prods[0:159];
  longint model_sat_count = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: exact integer sum wrapped to 40 bits, then round half up and clamp.
  function automatic longint model_out(input int n, output bit clamped);
    longint s = 0;
    longint r;
    for (int i = 0; i < n; i++) s += prods[i];
    s = (s <<< 24) >>> 24;
    r = (s + 65536) >>> 17;
    clamped = 1'b0;
    if (r > 32767) begin r = 32767; clamped = 1'b1; end
    if (r < -32768) begin r = -32768; clamped = 1'b1; end
    return r;
  endfunction

  function automatic longint rand_prod();
    longint v;
    case ($urandom_range(0, 2))
      0: begin
        v = {$urandom(), $urandom()};
        v = (v <<< 31) >>> 31;
      end
      1: v = longint'($urandom_range(0, 8000000)) - 4000000;
      default: v = longint'($urandom_range(0, 400000000)) - 200000000;
    endcase
    return v;
  endfunction

  // Drive prods[0..n-1] as one sample, hold the output `hold` cycles, then handshake.
  task automatic run_sample(input string tag, input int n, input int hold, input bit gaps);
    longint exp;
    bit     clamped;
    longint held;
    exp = model_out(n, clamped);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        prod_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      prod_data  = prods[i][32:0];
      prod_valid = 1'b1;
      prod_last  = (i == n - 1);
      if (i == 0 || i == n - 1) check({tag, "_ready_beat"}, longint'(prod_ready), 1);
      tick();
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check({tag, "_valid"}, longint'(out_valid), 1);
    check({tag, "_data"}, longint'($signed(out_data)), exp);
    check({tag, "_ready_hold"}, longint'(prod_ready), 0);
    if (clamped && model_sat_count < 65535) model_sat_count++;
`ifdef FILTER_ACC_SAT_STATUS_EN
    check({tag, "_sat_count"}, longint'(sat_count), model_sat_count);
`endif
    held = longint'($signed(out_data));
    for (int c = 0; c < hold; c++) begin
      prod_data  = 33'h0_1234_5678;
      prod_valid = 1'b1;
      tick();
      check({tag, "_bp_valid"}, longint'(out_valid), 1);
      check({tag, "_bp_data"}, longint'($signed(out_data)), held);
      check({tag, "_bp_ready"}, longint'(prod_ready), 0);
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    check({tag, "_release_valid"}, longint'(out_valid), 0);
    check({tag, "_release_ready"}, longint'(prod_ready), 1);
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    check("rst_async_valid", longint'(out_valid), 0);
    check("rst_async_data", longint'(out_data), 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("rst_ready", longint'(prod_ready), 1);
    check("rst_valid_after", longint'(out_valid), 0);
  endtask

  initial begin
    // Power-on reset state.
    repeat (2) tick();
    check("por_valid", longint'(out_valid), 0);
    check("por_data", longint'(out_data), 0);
    ap_rst_n = 1'b1;
    tick();
    check("por_ready", longint'(prod_ready), 1);
`ifdef FILTER_ACC_SAT_STATUS_EN
    check("por_sat_count", longint'(sat_count), 0);
`endif

    // Single tap: 1000 x 0.5 in Q1.17.
    prods[0] = 65536000;
    run_sample("single", 1, 0, 1'b0);
    check("single_value", model_out(1, prods[159][0]) , 500);

    // Rounding boundaries.
    prods[0] = 65536;   run_sample("rnd_half_pos", 1, 0, 1'b0);
    prods[0] = -65537;  run_sample("rnd_neg_below", 1, 0, 1'b0);
    prods[0] = -65536;  run_sample("rnd_neg_half", 1, 0, 1'b0);

    // Saturation both ways.
    for (int i = 0; i < 3; i++) prods[i] = 64'sd4294967295;
    run_sample("sat_pos", 3, 0, 1'b0);
    for (int i = 0; i < 3; i++) prods[i] = -64'sd4294967296;
    run_sample("sat_neg", 3, 0, 1'b0);

    // Backpressure for 5 cycles, then a clean follow-up sample.
    prods[0] = 1000000; prods[1] = -300000; prods[2] = 2500000;
    run_sample("bp", 3, 5, 1'b1);
    prods[0] = 131072; prods[1] = 262144;
    run_sample("after_bp", 2, 0, 1'b0);

    // Reset after 3 of 8 taps discards the partial sample.
    for (int i = 0; i < 3; i++) begin
      prod_data  = 33'd131072;
      prod_valid = 1'b1;
      tick();
    end
    prod_valid = 1'b0;
    do_reset();
    model_sat_count = 0;
    for (int i = 0; i < 8; i++) prods[i] = 131072;
    run_sample("post_reset8", 8, 0, 1'b0);

    // Reset while HOLD is pending drops the sample.
    prods[0] = 65536000;
    prod_data  = prods[0][32:0];
    prod_valid = 1'b1;
    prod_last  = 1'b1;
    tick();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check("hold_pending_valid", longint'(out_valid), 1);
    do_reset();
    model_sat_count = 0;

    // Accumulator wraps past 40 bits without detection.
    for (int i = 0; i < 129; i++) prods[i] = 64'sd4294967295;
    run_sample("wrap", 129, 0, 1'b0);
    for (int i = 0; i < 128; i++) prods[i] = -64'sd4294967296;
    run_sample("full_neg_128", 128, 0, 1'b0);

    // Random samples with gaps and backpressure.
    for (int s = 0; s < 40; s++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prods[i] = rand_prod();
      run_sample($sformatf("rand%0d", s), n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
